// File: rtl/router_pkt_pkg.sv
// Shared types for the router output-port collector: FSM states and the
// tagged byte entry stored in the receive FIFO.
package router_pkt_pkg;

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        COLLECT,
        DROP
    } collector_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eof;
        logic       err;
    } fifo_entry_t;

    localparam logic [7:0] ERR_MARKER = 8'h00;

endpackage

// File: rtl/router_pkt_collector_if.sv
// Byte stream from the collector to a scoreboard or monitor (valid/ready).
interface router_pkt_collector_if;

    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_sof;
    logic       m_eof;
    logic       m_err;

    modport master (output m_valid, m_data, m_sof, m_eof, m_err, input m_ready);
    modport slave  (input m_valid, m_data, m_sof, m_eof, m_err, output m_ready);

endinterface

// File: rtl/router_byte_fifo.sv
// Show-ahead FIFO of tagged bytes. The head entry reads as zero while empty;
// admission policy (reserved slot) is left to the parent.
module router_byte_fifo
    import router_pkt_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  fifo_entry_t              push_entry,
    input  logic                     pop,
    output fifo_entry_t              head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    fifo_entry_t   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign valid   = (count != '0);
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign head    = valid ? mem[rptr] : '0;

    // NOTE: storage has no reset; the pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wptr] <= push_entry;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/router_pkt_collector.sv
// Samples one router output port (LSB-first serial), packs bytes and queues
// them with sof/eof/err tags; the last FIFO slot is kept for frame terminators.
module router_pkt_collector
    import router_pkt_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 dout,
    input  logic                 valido_n,
    input  logic                 frameo_n,
    input  logic                 clr_stat,
    router_pkt_collector_if.master stream,
    output logic [CNT_W-1:0]     pkt_count,
    output logic                 overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DATA_LIMIT = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] EOF_LIMIT  = (AW+1)'(DEPTH);

    collector_state_e state;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             first_pending;

    logic [AW:0]      count;
    fifo_entry_t      head;
    fifo_entry_t      want_entry;
    logic [7:0]       new_byte;
    logic             head_valid;
    logic             want_push;
    logic             room;
    logic             push;
    logic             good_frame;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        new_byte          = shreg;
        new_byte[bit_cnt] = dout;
        want_push         = 1'b0;
        want_entry        = '{data: ERR_MARKER, sof: first_pending, eof: 1'b1, err: 1'b1};
        case (state)
            COLLECT: begin
                if (!valido_n) begin
                    if (bit_cnt == 3'd7) begin
                        want_push  = 1'b1;
                        want_entry = '{data: new_byte, sof: first_pending, eof: frameo_n, err: 1'b0};
                    end else if (frameo_n) begin
                        want_push       = 1'b1;
                        want_entry.data = new_byte;
                    end
                end else if (frameo_n) begin
                    want_push = !first_pending || (bit_cnt != 3'd0);
                end
            end
            DROP:    want_push = frameo_n;
            default: want_push = 1'b0;
        endcase
    end

    // Data bytes may not take the last slot; terminators may.
    assign room       = want_entry.eof ? (count < EOF_LIMIT) : (count < DATA_LIMIT);
    assign push       = want_push && room;
    assign good_frame = push && want_entry.eof && !want_entry.err;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= SYNC;
            bit_cnt       <= '0;
            shreg         <= '0;
            first_pending <= 1'b0;
            pkt_count     <= '0;
            overflow      <= 1'b0;
        end else begin
            if (good_frame)     pkt_count <= clr_stat ? CNT_W'(1) : pkt_count + 1'b1;
            else if (clr_stat)  pkt_count <= '0;

            if (want_push && !room) overflow <= 1'b1;
            else if (clr_stat)      overflow <= 1'b0;

            case (state)
                SYNC: if (frameo_n) state <= IDLE;
                IDLE: begin
                    if (!frameo_n) begin
                        state         <= COLLECT;
                        first_pending <= 1'b1;
                        shreg         <= {7'b0, dout & !valido_n};
                        bit_cnt       <= {2'b0, !valido_n};
                    end
                end
                COLLECT: begin
                    if (want_push) begin
                        shreg   <= '0;
                        bit_cnt <= '0;
                        if (!room) begin
                            // A rejected terminator means nothing of this frame was queued.
                            state <= want_entry.eof ? IDLE : DROP;
                        end else begin
                            first_pending <= 1'b0;
                            if (want_entry.eof) state <= IDLE;
                        end
                    end else if (frameo_n) begin
                        state <= IDLE;
                    end else if (!valido_n) begin
                        shreg   <= new_byte;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DROP: begin
                    if (frameo_n) begin
                        state   <= IDLE;
                        shreg   <= '0;
                        bit_cnt <= '0;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

    router_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (want_entry),
        .pop        (head_valid && stream.m_ready),
        .head       (head),
        .valid      (head_valid),
        .count      (count)
    );

    assign stream.m_valid = head_valid;
    assign stream.m_data  = head.data;
    assign stream.m_sof   = head.sof;
    assign stream.m_eof   = head.eof;
    assign stream.m_err   = head.err;

endmodule

// File: tb/tb_router_pkt_collector.sv
// Bench for router_pkt_collector: frame vectors from a table feed a scoreboard
// queue; hand-written sequences cover overflow, reset and statistics corners.
module tb_router_pkt_collector;
    import router_pkt_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic             clock    = 1'b0;
    logic             reset_n  = 1'b1;
    logic             dout     = 1'b0;
    logic             valido_n = 1'b1;
    logic             frameo_n = 1'b1;
    logic             clr_stat = 1'b0;
    logic [CNT_W-1:0] pkt_count;
    logic             overflow;

    router_pkt_collector_if stream ();

    router_pkt_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .dout      (dout),
        .valido_n  (valido_n),
        .frameo_n  (frameo_n),
        .clr_stat  (clr_stat),
        .stream    (stream),
        .pkt_count (pkt_count),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_pass   = 0;
    fifo_entry_t exp_q[$];

    typedef struct {
        int               nbits;
        logic [31:0]      bits;
        logic [CNT_W-1:0] cnt_after;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Consumer side: every accepted entry is compared with the scoreboard head.
    always @(negedge clock) begin
        if (reset_n && stream.m_valid && stream.m_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_entry: got data 0x%0h sof %0b eof %0b err %0b, expected none",
                         stream.m_data, stream.m_sof, stream.m_eof, stream.m_err);
            end else begin
                fifo_entry_t e;
                e = exp_q.pop_front();
                check("entry", 32'({stream.m_data, stream.m_sof, stream.m_eof, stream.m_err}), 32'(e));
            end
        end
    end

    task automatic expect_entry(input logic [7:0] d, input logic sof, input logic eof, input logic err);
        fifo_entry_t e;
        e = '{data: d, sof: sof, eof: eof, err: err};
        exp_q.push_back(e);
    endtask

    // Frame-level model: whole bytes first, then a zero-padded partial byte flagged err.
    task automatic expect_frame(input int nbits, input logic [31:0] bits);
        int          nfull;
        int          rem;
        logic [7:0]  mask;
        logic [31:0] rest;
        nfull = nbits / 8;
        rem   = nbits % 8;
        for (int k = 0; k < nfull; k++)
            expect_entry(bits[k*8 +: 8], k == 0, (rem == 0) && (k == nfull - 1), 1'b0);
        if (rem != 0) begin
            mask = 8'((1 << rem) - 1);
            rest = bits >> (nfull * 8);
            expect_entry(rest[7:0] & mask, nfull == 0, 1'b1, 1'b1);
        end
    endtask

    task automatic drive(input logic d, input logic vn, input logic fn, input logic clr);
        @(posedge clock);
        #2;
        dout     = d;
        valido_n = vn;
        frameo_n = fn;
        clr_stat = clr;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic send_frame(input int nbits, input logic [31:0] bits, input logic clr_last);
        for (int i = 0; i < nbits; i++)
            drive(bits[i], 1'b0, i == nbits - 1, clr_last && (i == nbits - 1));
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || stream.m_valid) && n < 300) begin
            @(negedge clock);
            n++;
        end
        check(name, {30'b0, exp_q.size() != 0, stream.m_valid}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        stream.m_ready = 1'b1;
        vecs[0] = '{16, 32'h0000_3CA5, 16'd1};
        vecs[1] = '{12, 32'h0000_075A, 16'd1};
        vecs[2] = '{ 8, 32'h0000_0011, 16'd2};
        vecs[3] = '{24, 32'h0000_FF80, 16'd3};
        vecs[4] = '{ 3, 32'h0000_0005, 16'd3};
        vecs[5] = '{32, 32'hDEAD_BEEF, 16'd4};

        #1 reset_n = 1'b0;
        #2;
        check("reset_m_valid", 32'(stream.m_valid), 32'd0);
        check("reset_m_flags", 32'({stream.m_data, stream.m_sof, stream.m_eof, stream.m_err}), 32'd0);
        check("reset_pkt_count", 32'(pkt_count), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        idle(3);

        for (int v = 0; v < 6; v++) begin
            expect_frame(vecs[v].nbits, vecs[v].bits);
            send_frame(vecs[v].nbits, vecs[v].bits, 1'b0);
            idle(2);
            wait_drain("vec_drain");
            check("vec_pkt_count", 32'(pkt_count), 32'(vecs[v].cnt_after));
        end

        // Empty envelope pushes nothing; a bitless end after 4 bits pushes a marker.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);
        expect_entry(8'h00, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        wait_drain("marker_drain");
        check("marker_pkt_count", 32'(pkt_count), 32'd4);

        // Overflow: 20 bytes into a stalled FIFO keeps 15 bytes plus an error marker.
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        stream.m_ready = 1'b0;
        for (int k = 0; k < 15; k++) expect_entry(8'(8'h10 + k), k == 0, 1'b0, 1'b0);
        expect_entry(8'h00, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 20; k++) begin
            b = 8'(8'h10 + k);
            for (int i = 0; i < 8; i++) drive(b[i], 1'b0, (k == 19) && (i == 7), 1'b0);
        end
        idle(2);
        @(negedge clock);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_head", 32'({stream.m_valid, stream.m_data, stream.m_sof}), 32'({1'b1, 8'h10, 1'b1}));
        check("ovf_pkt_count", 32'(pkt_count), 32'd4);
        repeat (3) @(negedge clock);
        check("ovf_head_stable", 32'(stream.m_data), 32'h10);
        stream.m_ready = 1'b1;
        wait_drain("ovf_drain");

        // Plain statistics clear.
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        idle(1);
        @(negedge clock);
        check("clr_pkt_count", 32'(pkt_count), 32'd0);
        check("clr_overflow", 32'(overflow), 32'd0);

        // Back-to-back frames separated only by the last-bit cycle.
        expect_frame(8, 32'h11);
        expect_frame(8, 32'h22);
        send_frame(8, 32'h11, 1'b0);
        send_frame(8, 32'h22, 1'b0);
        idle(2);
        wait_drain("b2b_drain");
        check("b2b_pkt_count", 32'(pkt_count), 32'd2);

        // Clear coinciding with a good eof push: the increment wins.
        expect_frame(8, 32'h33);
        send_frame(8, 32'h33, 1'b1);
        idle(2);
        wait_drain("clr_eof_drain");
        check("clr_eof_pkt_count", 32'(pkt_count), 32'd1);

        // Reset mid-frame: the rest of that frame is ignored until frameo_n rises.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #2 reset_n = 1'b0;
        @(negedge clock);
        check("midrst_m_valid", 32'(stream.m_valid), 32'd0);
        check("midrst_pkt_count", 32'(pkt_count), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        idle(1);
        expect_frame(8, 32'h81);
        send_frame(8, 32'h81, 1'b0);
        idle(2);
        wait_drain("midrst_drain");
        check("midrst_final_count", 32'(pkt_count), 32'd1);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
